// File: rtl/i2s_dac_tx_if.sv
// Sample stream into the I2S DAC transmitter and the serial/status lines coming back out.
// The transmitter side connects through the slave modport.
interface i2s_dac_tx_if #(
  parameter int unsigned SIG_BITS   = 16,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;

  logic [SIG_BITS-1:0] in;
  logic                in_valid;
  logic                bclk;
  logic                lrclk;
  logic                dacdat;
  logic                underrun;
  logic                overrun;
  logic [LvlW-1:0]     fifo_level;

  modport master (
    output in,
    output in_valid,
    input  bclk,
    input  lrclk,
    input  dacdat,
    input  underrun,
    input  overrun,
    input  fifo_level
  );

  modport slave (
    input  in,
    input  in_valid,
    output bclk,
    output lrclk,
    output dacdat,
    output underrun,
    output overrun,
    output fifo_level
  );
endinterface

// File: rtl/i2s_dac_tx.sv
// Mono sample FIFO feeding an I2S master serialiser (64 BCLK per frame, 32 per channel).
// Every output is registered; samples are popped at the falling BCLK edge that enters slot 0.
module i2s_dac_tx #(
  parameter int unsigned SIG_BITS   = 16,
  parameter int unsigned HALF_DIV   = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic         clk,
  input logic         reset_n,
  i2s_dac_tx_if.slave bus
);
  localparam int unsigned DivW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LvlW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [DivW-1:0] DivLast  = DivW'(HALF_DIV - 1);
  localparam logic [LvlW-1:0] LvlFull  = LvlW'(FIFO_DEPTH);
  localparam logic [4:0]      SigBits5 = 5'(SIG_BITS);
  localparam logic [5:0]      SlotLast = 6'd63;

  // Bit clock and slot tracking
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            bclk_q, bclk_d;
  logic [5:0]      slot_q, slot_d;
  logic            lrclk_q, lrclk_d;
  logic            dacdat_q, dacdat_d;

  // Sample path
  logic [SIG_BITS-1:0] tx_sample_q, tx_sample_d;
  logic [SIG_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]     level_q, level_d;

  logic underrun_q, underrun_d;
  logic overrun_q, overrun_d;

  logic       div_wrap;
  logic       bclk_fall;
  logic       frame_start;
  logic       fifo_empty;
  logic       pop;
  logic       push;
  logic [4:0] bit_k;
  logic [4:0] bit_idx;
  logic       bit_sel;

  always_comb begin
    div_wrap    = (div_cnt_q == DivLast);
    bclk_fall   = div_wrap & bclk_q;
    frame_start = bclk_fall & (slot_q == SlotLast);
    fifo_empty  = (level_q == '0);
    // Pop sees the pre-push level; a pop frees a slot for a same-cycle push.
    pop         = frame_start & ~fifo_empty;
    push        = bus.in_valid & ((level_q != LvlFull) | pop);
  end

  always_comb begin
    div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
    bclk_d    = div_wrap ? ~bclk_q : bclk_q;
    slot_d    = bclk_fall ? slot_q + 6'd1 : slot_q;
  end

  // Serialiser: slot bit k carries tx_sample[SIG_BITS-k] for k in 1..SIG_BITS.
  always_comb begin
    bit_k   = slot_d[4:0];
    bit_idx = SigBits5 - bit_k;
    bit_sel = 1'b0;
    for (int i = 0; i < int'(SIG_BITS); i++) begin
      if (bit_idx == 5'(i)) bit_sel = tx_sample_q[i];
    end
    lrclk_d  = lrclk_q;
    dacdat_d = dacdat_q;
    if (bclk_fall) begin
      lrclk_d  = slot_d[5];
      dacdat_d = (bit_k != 5'd0) && (bit_k <= SigBits5) && bit_sel;
    end
  end

  always_comb begin
    tx_sample_d = pop ? mem_q[rd_ptr_q] : tx_sample_q;
    rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    level_d     = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
    underrun_d = frame_start & fifo_empty;
    overrun_d  = bus.in_valid & ~push;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q   <= '0;
      bclk_q      <= 1'b0;
      slot_q      <= SlotLast;
      lrclk_q     <= 1'b0;
      dacdat_q    <= 1'b0;
      tx_sample_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      bclk_q      <= bclk_d;
      slot_q      <= slot_d;
      lrclk_q     <= lrclk_d;
      dacdat_q    <= dacdat_d;
      tx_sample_q <= tx_sample_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in;
  end

  assign bus.bclk       = bclk_q;
  assign bus.lrclk      = lrclk_q;
  assign bus.dacdat     = dacdat_q;
  assign bus.underrun   = underrun_q;
  assign bus.overrun    = overrun_q;
  assign bus.fifo_level = level_q;
endmodule
